// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer slice.
package pc_pkg;

    localparam int INDEX_WIDTH_DEF = 9;
    localparam int LEN_WIDTH_DEF   = 8;
    localparam int PC_STEP         = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        COPY   = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

endpackage

// File: rtl/copy_counter.sv
// Copy index counter: loads the copy length, steps the index and flags the final word.
module copy_counter #(
    parameter int Len_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [Len_width-1:0] len_i,
    input  logic                 inc_i,
    input  logic                 clear_i,
    output logic [Len_width-1:0] count_o,
    output logic                 last_o
);

    logic [Len_width-1:0] count_q;
    logic [Len_width-1:0] len_q;

    // Index 0 belongs to the start cycle, so a load begins counting at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {Len_width{1'b0}};
            len_q   <= {Len_width{1'b0}};
        end else if (load_i) begin
            count_q <= Len_width'(1);
            len_q   <= len_i;
        end else if (clear_i) begin
            count_q <= {Len_width{1'b0}};
        end else if (inc_i) begin
            count_q <= count_q + Len_width'(1);
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == (len_q - Len_width'(1)));

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer: branch load, multi-cycle copy stall and sticky halt.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                   Index_width  = INDEX_WIDTH_DEF,
    parameter int                   Len_width    = LEN_WIDTH_DEF,
    parameter logic [Index_width-1:0] Reset_vector = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [Index_width-1:0] Next_value,
    output logic [Index_width-1:0] Current_value,
    output logic                   mem_copy,
    input  logic                   branch_en,
    input  logic [Index_width-1:0] branch_target,
    input  logic                   copy_start,
    input  logic [Len_width-1:0]   copy_len,
    output logic                   copy_active,
    output logic [Len_width-1:0]   copy_idx,
    output logic                   copy_done,
    output logic                   halted,
    input  logic                   halt
);

    localparam logic [Index_width-1:0] ALIGN_MASK = ~(Index_width'(PC_STEP - 1));

    pc_state_t              state_q;
    logic [Index_width-1:0] pc_q;
    logic                   start_s;
    logic                   single_s;
    logic                   load_s;
    logic                   in_copy_s;
    logic                   last_s;
    logic [Len_width-1:0]   count_s;

    // A copy starts only when neither halt nor branch wins and the length is non-zero.
    assign start_s   = (state_q == RUN) && !halt && !branch_en && copy_start
                       && (copy_len != {Len_width{1'b0}});
    assign single_s  = start_s && (copy_len == Len_width'(1));
    assign load_s    = start_s && !single_s;
    assign in_copy_s = (state_q == COPY);

    copy_counter #(
        .Len_width (Len_width)
    ) u_copy_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_s),
        .len_i   (copy_len),
        .inc_i   (in_copy_s && !last_s),
        .clear_i (in_copy_s && last_s),
        .count_o (count_s),
        .last_o  (last_s)
    );

    // Copy handshake outputs follow the current cycle's decision.
    always_comb begin
        copy_active = start_s || in_copy_s;
        copy_done   = single_s || (in_copy_s && last_s);
        mem_copy    = load_s || (in_copy_s && !last_s);
        if (in_copy_s) begin
            copy_idx = count_s;
        end else begin
            copy_idx = {Len_width{1'b0}};
        end
    end

    // Sequencer FSM and PC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= Reset_vector;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else if (branch_en) begin
                        pc_q <= branch_target & ALIGN_MASK;
                    end else if (load_s) begin
                        state_q <= COPY;
                    end else begin
                        pc_q <= Next_value;
                    end
                end
                COPY: begin
                    if (last_s) begin
                        pc_q    <= Next_value;
                        state_q <= RUN;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign Current_value = pc_q;
    assign halted        = (state_q == HALTED);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and fetch sequencer for the single-cycle core.
- Sits opposite the PC increment ALU: drives that ALU's Current_value and mem_copy inputs, and registers its Next_value result each cycle.
- Adds branch load, a multi-cycle memory-copy stall sequence with an index counter, and a sticky halt.

Parameters:
- Index_width, 9, PC width in bits; PC wraps modulo 2^Index_width.
- Len_width, 8, width of the copy length and copy index.
- Reset_vector, 0, PC value after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Next_value  in  Index_width  next PC from the increment ALU
- Current_value  out  Index_width  registered PC; drives the ALU and instruction memory address
- mem_copy  out  1  hold request to the ALU (Next_value = Current_value)
- branch_en  in  1  load branch_target this cycle
- branch_target  in  Index_width  branch destination; bits [1:0] are forced to 0 on load
- copy_start  in  1  the instruction at the current PC is a copy of copy_len words
- copy_len  in  Len_width  word count; sampled only with copy_start
- copy_active  out  1  a copy is in progress this cycle (combinational)
- copy_idx  out  Len_width  word index of the current copy cycle
- copy_done  out  1  single-cycle pulse on the final copy cycle (combinational)
- halted  out  1  core halted
- halt  in  1  halt request

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: Current_value = Reset_vector; state = RUN; internal count = 0; internal latched length = 0. All outputs deassert: mem_copy, copy_active, copy_done, halted = 0 and copy_idx = 0.
- Reset has top priority and aborts any copy in progress or halt.
- States: RUN, COPY, HALTED.
- RUN, priority order applied at each edge:
  - halt -> HALTED, PC unchanged.
  - Else branch_en -> PC <= {branch_target[Index_width-1:2], 2'b00}; a simultaneous copy_start is dropped.
  - Else copy_start with copy_len = N >= 1 -> start cycle.
  - Else (including copy_start with copy_len = 0, treated as a NOP) -> PC <= Next_value.
- Copy sequence, N cycles total:
  - Start cycle: copy_active = 1 and copy_idx = 0.
  - If N = 1: copy_done = 1, mem_copy = 0, PC <= Next_value, stay in RUN.
  - If N > 1: mem_copy = 1 (PC held), latch N, count <= 1, go to COPY.
- COPY:
  - copy_active = 1 and copy_idx = count.
  - If count == N-1: copy_done = 1, mem_copy = 0, PC <= Next_value, go to RUN.
  - Otherwise: mem_copy = 1 and count <= count + 1.
  - branch_en, halt and copy_start are ignored; halt must be held until the copy finishes.
- Net effect: PC holds the copy instruction's address for exactly N cycles, then advances once. mem_copy is high for exactly N-1 cycles.
- HALTED: PC frozen, halted = 1, mem_copy = 0, all inputs ignored. Exit only through reset.
- Outputs outside a copy: copy_idx = 0, copy_active = 0, copy_done = 0.
- Width rules: PC arithmetic belongs to the ALU, and Next_value is taken unmodified, so wrap from 2^Index_width-4 to 0 is inherited. The index counter never exceeds N-1, so it cannot overflow Len_width.

Decomposition:
- Shared package (pc_pkg):
  - state enum pc_state_t {RUN, COPY, HALTED};
  - constant PC_STEP = 4;
  - default widths for Index_width and Len_width.
- One sub-module: copy_counter (load, increment, last-flag comparison against the latched N).
- Top level contains the FSM and the PC register. The increment ALU is instantiated by the parent, not inside this block.

Test Plan:
1. Reset then free-run, with the ALU model giving Next_value = Current_value + 4. Expect PC 0, 4, 8, 12. After the PC reaches 508, the next value is 0 (Index_width = 9).
2. copy_start with copy_len = 3 at PC = 16:
   - mem_copy = 1, 1, 0; copy_idx = 0, 1, 2; copy_done only in the 3rd cycle.
   - PC = 16 for 3 cycles, then 20.
3. Length edge cases:
   - copy_len = 1 at PC = 8: one cycle, mem_copy never high, copy_done = 1, next PC = 12.
   - copy_len = 0: behaves as a NOP, next PC = 12.
4. Simultaneous inputs:
   - branch_en with branch_target = 0x1FF and copy_start in the same RUN cycle: PC <= 0x1FC, no copy.
   - branch_en during COPY: ignored.
5. halt:
   - halt asserted during a copy_len = 4 copy: completes all 4 copy cycles. If halt is still high in the next RUN cycle, go to HALTED with PC frozen at copy address + 4 and halted = 1.
   - A subsequent branch_en has no effect.
6. rst_n low in COPY with copy_idx = 2: next edge gives PC = Reset_vector, mem_copy = 0, copy_active = 0, copy_idx = 0, state RUN.
